// File: rtl/fetch_pkg.sv
// fetch_pkg: memory FSM states, opcodes and IR field positions shared by the fetch unit
package fetch_pkg;
  typedef enum logic {M_IDLE, M_WAIT} mem_state_t;
  typedef enum logic [2:0] {OP_ADD = 3'b000, OP_LOAD = 3'b100, OP_STORE = 3'b101, OP_HALT = 3'b111} opcode_t;
  localparam int OPC_LSB = 13;
  localparam int RD_LSB = 10;
  localparam int RS_LSB = 7;
  localparam int RT_LSB = 4;
  localparam int IMM_W = 7;
endpackage

// File: rtl/fetch_mem_unit_if.sv
// fetch_mem_unit_if: single-port memory bus between the fetch unit (master) and memory (slave)
interface fetch_mem_unit_if #(parameter int DATA_W = 16, parameter int ADDR_W = 8);
  logic mem_req, mem_we, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  modport master(output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave(input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/fetch_mem_unit_mem_port_fsm.sv
// mem_port_fsm: issues and stretches one memory request at a time, latching address/data at issue
module mem_port_fsm
  import fetch_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              iord,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] wr_data,
  fetch_mem_unit_if.master  bus,
  output logic              mem_busy,
  output logic              rd_done,
  output logic              proto_err
);
  mem_state_t state;
  logic start;
  assign start = mem_read | mem_write;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state         <= M_IDLE;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      proto_err     <= 1'b0;
    end else if (state == M_IDLE) begin
      if (start) begin
        state         <= M_WAIT;
        bus.mem_addr  <= iord ? data_addr : pc;
        bus.mem_we    <= mem_write & ~mem_read;
        bus.mem_wdata <= wr_data;
        proto_err     <= proto_err | (mem_read & mem_write);
      end
    end else if (bus.mem_ready) state <= M_IDLE;
  assign bus.mem_req = state == M_WAIT;
  // control holds its strobes while busy, so the issue cycle and every wait cycle stall it
  assign mem_busy = (state == M_IDLE) ? start : ~bus.mem_ready;
  assign rd_done = bus.mem_req & bus.mem_ready & ~bus.mem_we;
endmodule

// File: rtl/fetch_mem_unit.sv
// fetch_mem_unit: PC/IR/MDR registers, instruction field decode and the single memory port
module fetch_mem_unit
  import fetch_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCWrite,
  input  logic              PCWriteCond,
  input  logic              IRWrite,
  input  logic              IorD,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              zero_flag,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wr_data,
  fetch_mem_unit_if.master  bus,
  output logic              mem_busy,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mdr,
  output logic [2:0]        opcode,
  output logic [2:0]        rd,
  output logic [2:0]        rs,
  output logic [2:0]        rt,
  output logic [DATA_W-1:0] imm_ext,
  output logic              halted,
  output logic              proto_err
);
  logic rd_done;
  logic unused_hi;
  mem_port_fsm #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port (
    .clk       (clk),
    .reset     (reset),
    .mem_read  (MemRead),
    .mem_write (MemWrite),
    .iord      (IorD),
    .pc        (pc),
    .data_addr (alu_out[ADDR_W-1:0]),
    .wr_data   (wr_data),
    .bus       (bus),
    .mem_busy  (mem_busy),
    .rd_done   (rd_done),
    .proto_err (proto_err)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc     <= RESET_PC;
      ir     <= '0;
      mdr    <= '0;
      halted <= 1'b0;
    end else begin
      if (!mem_busy && !halted)
        pc <= PCWrite ? alu_result[ADDR_W-1:0] : (PCWriteCond && zero_flag) ? alu_out[ADDR_W-1:0] : pc;
      if (rd_done) mdr <= bus.mem_rdata;
      if (rd_done && IRWrite) begin
        ir     <= bus.mem_rdata;
        halted <= halted | (bus.mem_rdata[OPC_LSB +: 3] == OP_HALT);
      end
    end
  assign opcode = ir[OPC_LSB +: 3];
  assign rd = ir[RD_LSB +: 3];
  assign rs = ir[RS_LSB +: 3];
  assign rt = ir[RT_LSB +: 3];
  assign imm_ext = {{(DATA_W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
  assign unused_hi = ^{alu_result[DATA_W-1:ADDR_W], alu_out[DATA_W-1:ADDR_W]};
endmodule

// File: tb/tb_fetch_mem_unit.sv
// tb_fetch_mem_unit: directed scenarios plus randomized traffic against a transaction-level model
module tb_fetch_mem_unit;
  localparam int DW = 16;
  localparam int AW = 8;
  logic clk = 1'b0, reset = 1'b1;
  logic PCWrite = 1'b0, PCWriteCond = 1'b0, IRWrite = 1'b0, IorD = 1'b0;
  logic MemRead = 1'b0, MemWrite = 1'b0, zero_flag = 1'b0;
  logic [DW-1:0] alu_result = '0, alu_out = '0, wr_data = '0;
  logic mem_busy, halted, proto_err;
  logic [AW-1:0] pc;
  logic [DW-1:0] ir, mdr, imm_ext;
  logic [2:0] opcode, rd, rs, rt;
  int checks = 0, errors = 0;

  fetch_mem_unit_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  fetch_mem_unit #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IRWrite(IRWrite),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .zero_flag(zero_flag),
    .alu_result(alu_result), .alu_out(alu_out), .wr_data(wr_data), .bus(bus),
    .mem_busy(mem_busy), .pc(pc), .ir(ir), .mdr(mdr), .opcode(opcode), .rd(rd), .rs(rs), .rt(rt),
    .imm_ext(imm_ext), .halted(halted), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Transaction-level model: one outstanding memory transaction plus architectural registers
  logic [AW-1:0] m_pc = '0, m_addr = '0;
  logic [DW-1:0] m_ir = '0, m_mdr = '0, m_wdata = '0;
  bit m_halt = 0, m_perr = 0, m_pend = 0, m_we = 0;
  logic [DW-1:0] mem [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic commit_pc();
    if (!m_halt) begin
      if (PCWrite) m_pc = alu_result[AW-1:0];
      else if (PCWriteCond && zero_flag) m_pc = alu_out[AW-1:0];
    end
  endtask

  always @(posedge clk or negedge reset)
    if (!reset) begin
      m_pc = '0; m_ir = '0; m_mdr = '0; m_halt = 0; m_perr = 0;
      m_pend = 0; m_we = 0; m_addr = '0; m_wdata = '0;
    end else if (m_pend) begin
      if (bus.mem_ready) begin
        m_pend = 0;
        commit_pc();
        if (m_we) mem[m_addr] = m_wdata;
        else begin
          m_mdr = bus.mem_rdata;
          if (IRWrite) begin
            m_ir = bus.mem_rdata;
            if (m_ir[15:13] == 3'b111) m_halt = 1;
          end
        end
      end
    end else if (MemRead || MemWrite) begin
      m_pend = 1;
      m_addr = IorD ? alu_out[AW-1:0] : m_pc;
      m_we = MemWrite && !MemRead;
      m_wdata = wr_data;
      if (MemRead && MemWrite) m_perr = 1;
    end else commit_pc();

  always @(negedge clk)
    if (reset) begin
      chk("busy", mem_busy, m_pend ? !bus.mem_ready : (MemRead || MemWrite));
      chk("req", bus.mem_req, m_pend);
      if (m_pend) begin
        chk("addr", bus.mem_addr, m_addr);
        chk("we", bus.mem_we, m_we);
        chk("wdata", bus.mem_wdata, m_wdata);
      end
      chk("pc", pc, m_pc);
      chk("ir", ir, m_ir);
      chk("mdr", mdr, m_mdr);
      chk("halted", halted, m_halt);
      chk("proto_err", proto_err, m_perr);
      chk("opcode", opcode, m_ir[15:13]);
      chk("rd", rd, m_ir[12:10]);
      chk("rs", rs, m_ir[9:7]);
      chk("rt", rt, m_ir[6:4]);
      chk("imm_ext", imm_ext, {{9{m_ir[6]}}, m_ir[6:0]});
    end

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  task automatic strobes(input logic pw, pwc, irw, iord, mr, mw);
    PCWrite = pw; PCWriteCond = pwc; IRWrite = irw; IorD = iord; MemRead = mr; MemWrite = mw;
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = {3'($urandom_range(0, 6)), 13'($urandom)};
    #2 reset = 1'b0;
    #1;
    chk("rst_pc", pc, 8'h00);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_addr", bus.mem_addr, 8'h00);
    chk("rst_wdata", bus.mem_wdata, 16'h0000);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_mdr", mdr, 16'h0000);
    chk("rst_halted", halted, 0);
    chk("rst_perr", proto_err, 0);
    #9 reset = 1'b1;
    nx();
    // fetch with zero wait states
    strobes(1, 0, 1, 0, 1, 0); alu_result = 16'h0001;
    @(negedge clk); chk("f_busy0", mem_busy, 1); chk("f_req0", bus.mem_req, 0);
    nx(); bus.mem_ready = 1'b1; bus.mem_rdata = 16'h8A05;
    @(negedge clk); chk("f_req1", bus.mem_req, 1); chk("f_addr", bus.mem_addr, 8'h00); chk("f_busy1", mem_busy, 0);
    nx(); strobes(0, 0, 0, 0, 0, 0); bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("f_ir", ir, 16'h8A05); chk("f_opc", opcode, 3'b100); chk("f_pc", pc, 8'h01);
    chk("f_rd", rd, 3'd2); chk("f_rs", rs, 3'd4); chk("f_imm", imm_ext, 16'h0005); chk("f_busy2", mem_busy, 0);
    // fetch with three wait states, PCWrite held throughout
    nx(); strobes(1, 0, 1, 0, 1, 0); alu_result = 16'h0002;
    for (int w = 0; w < 3; w++) begin
      nx();
      @(negedge clk); chk("w_busy", mem_busy, 1); chk("w_addr", bus.mem_addr, 8'h01); chk("w_pc", pc, 8'h01);
    end
    nx(); bus.mem_ready = 1'b1; bus.mem_rdata = 16'h12C4;
    nx(); strobes(0, 0, 0, 0, 0, 0); bus.mem_ready = 1'b0;
    @(negedge clk); chk("w_pc_once", pc, 8'h02); chk("w_ir", ir, 16'h12C4); chk("w_imm", imm_ext, 16'hFFC4);
    // store
    nx(); strobes(0, 0, 0, 1, 0, 1); alu_out = 16'h0040; wr_data = 16'hBEEF;
    nx(); bus.mem_ready = 1'b1; bus.mem_rdata = 16'hFFFF;
    @(negedge clk); chk("s_we", bus.mem_we, 1); chk("s_addr", bus.mem_addr, 8'h40); chk("s_wdata", bus.mem_wdata, 16'hBEEF);
    nx(); strobes(0, 0, 0, 0, 0, 0); bus.mem_ready = 1'b0;
    @(negedge clk); chk("s_ir", ir, 16'h12C4); chk("s_mdr", mdr, 16'h12C4);
    // conditional branch taken, then not taken; stray mem_ready ignored
    nx(); strobes(0, 1, 0, 0, 0, 0); zero_flag = 1'b1; alu_out = 16'h0020; bus.mem_ready = 1'b1;
    @(negedge clk); chk("b_req", bus.mem_req, 0);
    nx(); zero_flag = 1'b0; alu_out = 16'h0030;
    @(negedge clk); chk("b_taken", pc, 8'h20);
    nx(); strobes(0, 0, 0, 0, 0, 0); bus.mem_ready = 1'b0;
    @(negedge clk); chk("b_not_taken", pc, 8'h20);
    // PC wrap, then HALT fetch freezes PC
    nx(); strobes(1, 0, 0, 0, 0, 0); alu_result = 16'h00FF;
    nx(); alu_result = 16'h0100;
    @(negedge clk); chk("pc_ff", pc, 8'hFF);
    nx(); strobes(0, 0, 1, 0, 1, 0);
    @(negedge clk); chk("pc_wrap", pc, 8'h00);
    nx(); bus.mem_ready = 1'b1; bus.mem_rdata = 16'hE000;
    nx(); strobes(0, 0, 0, 0, 0, 0); bus.mem_ready = 1'b0;
    @(negedge clk); chk("h_halted", halted, 1); chk("h_opc", opcode, 3'b111);
    nx(); strobes(1, 0, 0, 0, 0, 0); alu_result = 16'h0055;
    nx(); strobes(0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("h_pc_frozen", pc, 8'h00);
    // read and write together: read wins, proto_err sticks
    nx(); strobes(0, 0, 0, 0, 1, 1); wr_data = 16'h7777;
    nx(); bus.mem_ready = 1'b1; bus.mem_rdata = 16'h0ABC;
    @(negedge clk); chk("p_we", bus.mem_we, 0);
    nx(); strobes(0, 0, 0, 0, 0, 0); bus.mem_ready = 1'b0;
    @(negedge clk); chk("p_err", proto_err, 1); chk("p_mdr", mdr, 16'h0ABC); chk("p_ir", ir, 16'hE000);
    // asynchronous reset while a request is waiting
    nx(); strobes(0, 0, 1, 0, 1, 0);
    nx(); chk("r_req_before", bus.mem_req, 1);
    reset = 1'b0;
    #1;
    chk("r_req", bus.mem_req, 0); chk("r_pc", pc, 8'h00); chk("r_halted", halted, 0); chk("r_perr", proto_err, 0);
    #1 reset = 1'b1;
    strobes(0, 0, 0, 0, 0, 0);
    // randomized traffic; control strobes are held while a transaction is outstanding
    for (int c = 0; c < 4000; c++) begin
      nx();
      if (!m_pend) begin
        int r;
        r = $urandom_range(0, 99);
        MemRead = (r < 40) || (r == 99);
        MemWrite = (r >= 40 && r < 55) || (r == 99);
        IorD = 1'($urandom);
        IRWrite = 1'($urandom);
        PCWrite = $urandom_range(0, 9) < 3;
        PCWriteCond = $urandom_range(0, 9) < 3;
        zero_flag = 1'($urandom);
        alu_result = 16'($urandom);
        alu_out = 16'($urandom);
        wr_data = {3'($urandom_range(0, 6)), 13'($urandom)};
      end
      bus.mem_ready = m_pend ? 1'($urandom) : ($urandom_range(0, 3) == 0);
      bus.mem_rdata = m_pend ? mem[m_addr] : 16'($urandom);
    end
    nx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
